// File: rtl/sdram_arbiter_if.sv
// Bundle of requester-side and SDRAM-side Avalon-MM signals for sdram_arbiter.
// Modports: slave (the arbiter's view), master (the environment's view).
interface sdram_arbiter_if #(
  parameter int NUM_PORTS     = 4,
  parameter int WORD_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 24
);
  logic [NUM_PORTS*ADDRESS_WIDTH-1:0] req_address;
  logic [NUM_PORTS-1:0]               req_read;
  logic [NUM_PORTS-1:0]               req_write;
  logic [NUM_PORTS*WORD_WIDTH-1:0]    req_writedata;
  logic [NUM_PORTS-1:0]               req_waitrequest;
  logic [WORD_WIDTH-1:0]              req_readdata;
  logic [NUM_PORTS-1:0]               req_readdatavalid;
  logic [ADDRESS_WIDTH-1:0]           sdram_address;
  logic                               sdram_read;
  logic                               sdram_write;
  logic [WORD_WIDTH-1:0]              sdram_writedata;
  logic                               sdram_waitrequest;
  logic [WORD_WIDTH-1:0]              sdram_readdata;
  logic                               sdram_readdatavalid;

  modport slave (
    input  req_address, req_read, req_write, req_writedata,
    output req_waitrequest, req_readdata, req_readdatavalid,
    output sdram_address, sdram_read, sdram_write, sdram_writedata,
    input  sdram_waitrequest, sdram_readdata, sdram_readdatavalid
  );

  modport master (
    output req_address, req_read, req_write, req_writedata,
    input  req_waitrequest, req_readdata, req_readdatavalid,
    input  sdram_address, sdram_read, sdram_write, sdram_writedata,
    output sdram_waitrequest, sdram_readdata, sdram_readdatavalid
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM SDRAM port among NUM_PORTS requesters,
// routing pipelined read beats back via an ID FIFO.
// Ports: clock, reset_n (async low), bus (sdram_arbiter_if.slave: req_* and sdram_*),
// protocol_error (sticky), stat_reads/stat_writes/stat_stalls.
// Optional macro SDRAM_ARB_STATS_EN enables the stat counters (else tied to 0).
module sdram_arbiter #(
  parameter int NUM_PORTS     = 4,
  parameter int WORD_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 24,
  parameter int MAX_PENDING   = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  sdram_arbiter_if.slave       bus,
  output logic                 protocol_error,
  output logic [31:0]          stat_reads,
  output logic [31:0]          stat_writes,
  output logic [31:0]          stat_stalls
);

  localparam int IW = $clog2(NUM_PORTS);
  localparam int PW = $clog2(MAX_PENDING);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t               state, state_nx;
  logic [IW-1:0]        g, g_nx;
  logic [IW-1:0]        last_grant, last_nx;
  logic [IW-1:0]        pick;
  logic                 found;
  int                   scan_idx;
  logic [NUM_PORTS-1:0] r;

  logic                 g_rd, g_wr;
  logic                 fifo_full;
  logic                 rd_o, wr_o;
  logic [NUM_PORTS-1:0] wait_o;
  logic                 accept, rd_acc, wr_acc;

  logic [IW-1:0]        fifo_mem [MAX_PENDING];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic [IW-1:0]        head;
  logic                 push, pop;

  assign r = bus.req_read | bus.req_write;

  // Scan from last_grant+1 with wrap; first requester wins.
  always_comb begin
    pick     = '0;
    found    = 1'b0;
    scan_idx = 0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      scan_idx = (int'(last_grant) + k) % NUM_PORTS;
      if (!found && r[scan_idx]) begin
        pick  = IW'(scan_idx);
        found = 1'b1;
      end
    end
  end

  assign g_rd      = bus.req_read[g];
  assign g_wr      = bus.req_write[g];
  assign fifo_full = (count == CW'(MAX_PENDING));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      g          <= '0;
      last_grant <= IW'(NUM_PORTS - 1);
    end else begin
      state      <= state_nx;
      g          <= g_nx;
      last_grant <= last_nx;
    end
  end

  always_comb begin
    state_nx = state;
    g_nx     = g;
    last_nx  = last_grant;
    rd_o     = 1'b0;
    wr_o     = 1'b0;
    wait_o   = '1;
    accept   = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          g_nx     = pick;
          state_nx = GRANTED;
        end
      end
      GRANTED: begin
        // read+write together is treated as a read
        rd_o      = g_rd & ~fifo_full;
        wr_o      = g_wr & ~g_rd;
        wait_o[g] = bus.sdram_waitrequest | (g_rd & fifo_full);
        accept    = (rd_o | wr_o) & ~bus.sdram_waitrequest;
        if (accept) begin
          last_nx  = g;
          state_nx = IDLE;
        end else if (!(g_rd | g_wr)) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign rd_acc = accept & rd_o;
  assign wr_acc = accept & wr_o;

  assign bus.sdram_address   = bus.req_address[g*ADDRESS_WIDTH +: ADDRESS_WIDTH];
  assign bus.sdram_writedata = bus.req_writedata[g*WORD_WIDTH +: WORD_WIDTH];
  assign bus.sdram_read      = rd_o;
  assign bus.sdram_write     = wr_o;
  assign bus.req_waitrequest = wait_o;

  assign push = rd_acc;
  assign pop  = bus.sdram_readdatavalid & (count != '0);
  assign head = fifo_mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= g;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign bus.req_readdata      = bus.sdram_readdata;
  assign bus.req_readdatavalid = pop ? (NUM_PORTS'(1) << head) : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      protocol_error <= 1'b0;
    end else if ((bus.sdram_readdatavalid && count == '0) ||
                 (state == GRANTED && g_rd && g_wr)) begin
      protocol_error <= 1'b1;
    end
  end

`ifdef SDRAM_ARB_STATS_EN
  logic stall;
  assign stall = (state == GRANTED) & wait_o[g];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_reads  <= '0;
      stat_writes <= '0;
      stat_stalls <= '0;
    end else begin
      if (rd_acc) stat_reads  <= stat_reads + 32'd1;
      if (wr_acc) stat_writes <= stat_writes + 32'd1;
      if (stall)  stat_stalls <= stat_stalls + 32'd1;
    end
  end
`else
  assign stat_reads  = '0;
  assign stat_writes = '0;
  assign stat_stalls = '0;
`endif

endmodule
